// File: rtl/pic_pkg.sv
// Shared constants for the 8259 command sequencer.
// This package holds the following:
//   - the FSM state encoding
//   - the OCW2 command codes
//   - the ICW/OCW bit positions
//   - the default bus and IRQ widths
package pic_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int IRQ_N_DEF  = 8;

    typedef enum logic [2:0] {
        ST_UNINIT    = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } pic_state_t;

    // OCW2 {R, SL, EOI} codes as seen on ocw2_cmd
    typedef enum logic [2:0] {
        OCW2_ROT_AEOI_CLR = 3'b000,
        OCW2_NS_EOI       = 3'b001,
        OCW2_NOP          = 3'b010,
        OCW2_S_EOI        = 3'b011,
        OCW2_ROT_AEOI_SET = 3'b100,
        OCW2_ROT_NS_EOI   = 3'b101,
        OCW2_SET_PRIO     = 3'b110,
        OCW2_ROT_S_EOI    = 3'b111
    } ocw2_cmd_t;

    // ICW1 bit positions
    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_LTIM = 3;

    // ICW4 bit positions
    localparam int ICW4_UPM  = 0;
    localparam int ICW4_AEOI = 1;
    localparam int ICW4_MS   = 2;
    localparam int ICW4_BUF  = 3;
    localparam int ICW4_SFNM = 4;

    // OCW3 bit positions
    localparam int OCW3_RIS  = 0;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_P    = 2;
    localparam int OCW3_SMM  = 5;
    localparam int OCW3_ESMM = 6;

endpackage

// File: rtl/pic_readback_mux.sv
// Read-back select for the 8259 data bus.
// When A0 is high, the mux returns the IMR.
// When A0 is low, it returns the IRR or the ISR, chosen by ris.
// The mux drives the bus only while a read is in progress and initialization is complete.
module pic_readback_mux
    import pic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IRQ_N  = IRQ_N_DEF
) (
    input  logic              read,
    input  logic              A0,
    input  logic              init_done,
    input  logic              ris,
    input  logic [IRQ_N-1:0]  imr,
    input  logic [IRQ_N-1:0]  irr,
    input  logic [IRQ_N-1:0]  isr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_en
);

    // Same-cycle register select and drive enable
    always_comb begin
        data_out_en = read & init_done;
        if (A0)
            data_out = DATA_W'(imr);
        else if (ris)
            data_out = DATA_W'(isr);
        else
            data_out = DATA_W'(irr);
    end

endmodule

// File: rtl/pic_command_sequencer.sv
// 8259 command sequencer.
// The block consumes the write strobes from the bus buffer.
// It walks the ICW1->ICW2->[ICW3]->[ICW4] chain and then holds the PIC configuration.
// It also keeps the operation-word state: the IMR, the last OCW2, and the OCW3 read and mask selects.
// Optional macro PIC_READBACK_EN enables the IRR/ISR/IMR read-back path.
module pic_command_sequencer
    import pic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IRQ_N  = IRQ_N_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] internal_bus,
    input  logic              ICW_1,
    input  logic              ICW_2_4,
    input  logic              OCW_1,
    input  logic              OCW_2,
    input  logic              OCW_3,
    input  logic              read,
    input  logic              A0,
    input  logic [IRQ_N-1:0]  irr,
    input  logic [IRQ_N-1:0]  isr,
    output logic              init_done,
    output logic              ltim,
    output logic              single,
    output logic              ic4,
    output logic [4:0]        vector_base,
    output logic [7:0]        cascade_cfg,
    output logic              upm,
    output logic              aeoi,
    output logic              ms,
    output logic              buf_mode,
    output logic              sfnm,
    output logic [IRQ_N-1:0]  imr,
    output logic              ocw2_valid,
    output logic [2:0]        ocw2_cmd,
    output logic [2:0]        ocw2_level,
    output logic              ris,
    output logic              smm,
    output logic              poll_cmd,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_en
);

    pic_state_t state;
    pic_state_t state_next;

    logic icw_accept;
    logic ocw1_accept;
    logic ocw2_accept;
    logic ocw3_accept;

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_UNINIT;
        else
            state <= state_next;
    end

    // Next state: ICW1 restarts the chain from anywhere; A0=1 writes advance it
    always_comb begin
        state_next = state;
        if (ICW_1) begin
            state_next = ST_WAIT_ICW2;
        end else if (ICW_2_4) begin
            case (state)
                ST_WAIT_ICW2: begin
                    if (!single)
                        state_next = ST_WAIT_ICW3;
                    else if (ic4)
                        state_next = ST_WAIT_ICW4;
                    else
                        state_next = ST_READY;
                end
                ST_WAIT_ICW3: state_next = ic4 ? ST_WAIT_ICW4 : ST_READY;
                ST_WAIT_ICW4: state_next = ST_READY;
                default:      state_next = state;
            endcase
        end
    end

    // State-derived outputs and strobe qualification (ICW1 overrides every other strobe)
    always_comb begin
        init_done   = (state == ST_READY);
        icw_accept  = ICW_2_4 & ~ICW_1 &
                      ((state == ST_WAIT_ICW2) | (state == ST_WAIT_ICW3) |
                       (state == ST_WAIT_ICW4));
        ocw1_accept = OCW_1 & ~ICW_1 & init_done;
        ocw2_accept = OCW_2 & ~ICW_1 & init_done;
        ocw3_accept = OCW_3 & ~ICW_1 & init_done;
    end

    // Initialization-word configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ltim        <= 1'b0;
            single      <= 1'b0;
            ic4         <= 1'b0;
            vector_base <= 5'd0;
            cascade_cfg <= 8'd0;
            upm         <= 1'b0;
            aeoi        <= 1'b0;
            ms          <= 1'b0;
            buf_mode    <= 1'b0;
            sfnm        <= 1'b0;
        end else if (ICW_1) begin
            ltim        <= internal_bus[ICW1_LTIM];
            single      <= internal_bus[ICW1_SNGL];
            ic4         <= internal_bus[ICW1_IC4];
            vector_base <= 5'd0;
            cascade_cfg <= 8'd0;
            upm         <= 1'b0;
            aeoi        <= 1'b0;
            ms          <= 1'b0;
            buf_mode    <= 1'b0;
            sfnm        <= 1'b0;
        end else if (icw_accept) begin
            case (state)
                ST_WAIT_ICW2: vector_base <= internal_bus[7:3];
                ST_WAIT_ICW3: cascade_cfg <= internal_bus[7:0];
                ST_WAIT_ICW4: begin
                    upm      <= internal_bus[ICW4_UPM];
                    aeoi     <= internal_bus[ICW4_AEOI];
                    ms       <= internal_bus[ICW4_MS];
                    buf_mode <= internal_bus[ICW4_BUF];
                    sfnm     <= internal_bus[ICW4_SFNM];
                end
                default: ;
            endcase
        end
    end

    // Operation-word state; ICW1 drops the mask and read/mask selects but keeps the last OCW2
    always_ff @(posedge clk) begin
        if (reset) begin
            imr        <= '0;
            ocw2_cmd   <= 3'd0;
            ocw2_level <= 3'd0;
            ris        <= 1'b0;
            smm        <= 1'b0;
        end else if (ICW_1) begin
            imr        <= '0;
            ris        <= 1'b0;
            smm        <= 1'b0;
        end else begin
            if (ocw1_accept)
                imr <= IRQ_N'(internal_bus);
            if (ocw2_accept) begin
                ocw2_cmd   <= internal_bus[7:5];
                ocw2_level <= internal_bus[2:0];
            end
            if (ocw3_accept) begin
                if (internal_bus[OCW3_RR])
                    ris <= internal_bus[OCW3_RIS];
                if (internal_bus[OCW3_ESMM])
                    smm <= internal_bus[OCW3_SMM];
            end
        end
    end

    // One-cycle command pulses for the priority logic
    always_ff @(posedge clk) begin
        if (reset) begin
            ocw2_valid <= 1'b0;
            poll_cmd   <= 1'b0;
        end else begin
            ocw2_valid <= ocw2_accept;
            poll_cmd   <= ocw3_accept & internal_bus[OCW3_P];
        end
    end

`ifdef PIC_READBACK_EN
    pic_readback_mux #(
        .DATA_W (DATA_W),
        .IRQ_N  (IRQ_N)
    ) u_readback (
        .read        (read),
        .A0          (A0),
        .init_done   (init_done),
        .ris         (ris),
        .imr         (imr),
        .irr         (irr),
        .isr         (isr),
        .data_out    (data_out),
        .data_out_en (data_out_en)
    );
`else
    // Read-back disabled: bus never driven, read-side inputs intentionally sunk
    logic unused_readback;
    assign unused_readback = ^{read, A0, irr, isr};
    assign data_out        = '0;
    assign data_out_en     = 1'b0;
`endif

endmodule
